// File: rtl/knn_topk_tracker_if.sv
// Candidate input, list status and sorted-result stream of the top-K nearest-neighbour tracker.
// The master side feeds candidates and control; the slave side is the tracker.
interface knn_topk_tracker_if #(
   parameter int K          = 8,
   parameter int DIST_WIDTH = 32,
   parameter int ID_WIDTH   = 16
);
   logic                     clear_in;
   logic                     data_valid_in;
   logic [DIST_WIDTH-1:0]    distance_sq_in;
   logic [ID_WIDTH-1:0]      vertex_id_in;
   logic                     ready_out;
   logic                     drain_in;
   logic [$clog2(K+1)-1:0]   count_out;
   logic [DIST_WIDTH-1:0]    worst_dist_out;
   logic                     result_valid_out;
   logic [DIST_WIDTH-1:0]    result_dist_out;
   logic [ID_WIDTH-1:0]      result_id_out;
   logic                     result_last_out;
   logic                     done_out;

   modport master (
      output clear_in, data_valid_in, distance_sq_in, vertex_id_in, drain_in,
      input  ready_out, count_out, worst_dist_out,
      input  result_valid_out, result_dist_out, result_id_out, result_last_out, done_out
   );

   modport slave (
      input  clear_in, data_valid_in, distance_sq_in, vertex_id_in, drain_in,
      output ready_out, count_out, worst_dist_out,
      output result_valid_out, result_dist_out, result_id_out, result_last_out, done_out
   );
endinterface

// File: rtl/knn_topk_tracker.sv
// Keeps the K nearest candidates of a query sorted by squared distance (slot 0 nearest)
// and streams them out nearest-first on request without disturbing the list.
//
// state   | meaning
// COLLECT | accept one candidate per cycle, parallel compare-and-shift insertion
// DRAIN   | emit slots 0..count-1 on consecutive cycles, candidates dropped
module knn_topk_tracker #(
   parameter int K          = 8,
   parameter int DIST_WIDTH = 32,
   parameter int ID_WIDTH   = 16
) (
   input  logic                clk_in,
   input  logic                rst_in,
   knn_topk_tracker_if.slave   bus
);
   localparam int CW = $clog2(K+1);
   localparam int IW = $clog2(K);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                 state;
   logic [DIST_WIDTH-1:0]  slot_dist [K];
   logic [ID_WIDTH-1:0]    slot_id   [K];
   logic [K-1:0]           slot_vld;
   logic [CW-1:0]          count;
   logic [IW-1:0]          idx;
   logic                   res_valid;
   logic [DIST_WIDTH-1:0]  res_dist;
   logic [ID_WIDTH-1:0]    res_id;
   logic                   res_last;
   logic                   done_r;

   logic [K-1:0]           gt;
   logic [DIST_WIDTH-1:0]  ins_dist [K];
   logic [ID_WIDTH-1:0]    ins_id   [K];
   logic [K-1:0]           ins_vld;
   logic [CW-1:0]          ins_count;
   logic [CW-1:0]          nxt_count;
   logic [DIST_WIDTH-1:0]  nxt_dist0;
   logic [ID_WIDTH-1:0]    nxt_id0;
   logic                   accept;
   logic [IW-1:0]          nidx;

   // Valid slots are contiguous and sorted, so gt is a thermometer code: the first set
   // bit is the insertion point, everything above it shifts down by one.
   always_comb begin
      for (int i = 0; i < K; i++)
         gt[i] = !slot_vld[i] || (slot_dist[i] > bus.distance_sq_in);
      ins_dist = slot_dist;
      ins_id   = slot_id;
      ins_vld  = slot_vld;
      if (gt[0]) begin
         ins_dist[0] = bus.distance_sq_in;
         ins_id[0]   = bus.vertex_id_in;
         ins_vld[0]  = 1'b1;
      end
      for (int i = 1; i < K; i++) begin
         if (gt[i]) begin
            if (gt[i-1]) begin
               ins_dist[i] = slot_dist[i-1];
               ins_id[i]   = slot_id[i-1];
               ins_vld[i]  = slot_vld[i-1];
            end else begin
               ins_dist[i] = bus.distance_sq_in;
               ins_id[i]   = bus.vertex_id_in;
               ins_vld[i]  = 1'b1;
            end
         end
      end
      accept    = (state == COLLECT) && bus.data_valid_in && (|gt);
      ins_count = (count == CW'(K)) ? count : count + CW'(1);
      nxt_count = accept ? ins_count   : count;
      nxt_dist0 = accept ? ins_dist[0] : slot_dist[0];
      nxt_id0   = accept ? ins_id[0]   : slot_id[0];
      nidx      = idx + IW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= COLLECT;
         slot_vld  <= '0;
         count     <= '0;
         idx       <= '0;
         res_valid <= 1'b0;
         res_dist  <= '0;
         res_id    <= '0;
         res_last  <= 1'b0;
         done_r    <= 1'b0;
         for (int i = 0; i < K; i++) begin
            slot_dist[i] <= '0;
            slot_id[i]   <= '0;
         end
      end else begin
         done_r <= 1'b0;
         if (bus.clear_in) begin
            state     <= COLLECT;
            slot_vld  <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_dist  <= '0;
            res_id    <= '0;
            res_last  <= 1'b0;
            if (bus.data_valid_in && state == COLLECT) begin
               slot_dist[0] <= bus.distance_sq_in;
               slot_id[0]   <= bus.vertex_id_in;
               slot_vld[0]  <= 1'b1;
               count        <= CW'(1);
            end
         end else if (state == COLLECT) begin
            if (accept) begin
               slot_dist <= ins_dist;
               slot_id   <= ins_id;
               slot_vld  <= ins_vld;
               count     <= ins_count;
            end
            // The first entry is taken from the post-insert list so a same-cycle
            // candidate is part of the stream.
            if (bus.drain_in) begin
               if (nxt_count == '0) begin
                  done_r <= 1'b1;
               end else begin
                  state     <= DRAIN;
                  idx       <= '0;
                  res_valid <= 1'b1;
                  res_dist  <= nxt_dist0;
                  res_id    <= nxt_id0;
                  res_last  <= (nxt_count == CW'(1));
               end
            end
         end else begin
            if (res_last) begin
               state     <= COLLECT;
               res_valid <= 1'b0;
               res_dist  <= '0;
               res_id    <= '0;
               res_last  <= 1'b0;
               done_r    <= 1'b1;
            end else begin
               idx      <= nidx;
               res_dist <= slot_dist[nidx];
               res_id   <= slot_id[nidx];
               res_last <= (CW'(nidx) == count - CW'(1));
            end
         end
      end
   end

   assign bus.ready_out        = (state == COLLECT);
   assign bus.count_out        = count;
   assign bus.worst_dist_out   = (count == CW'(K)) ? slot_dist[K-1] : '1;
   assign bus.result_valid_out = res_valid;
   assign bus.result_dist_out  = res_dist;
   assign bus.result_id_out    = res_id;
   assign bus.result_last_out  = res_last;
   assign bus.done_out         = done_r;
endmodule
